// File: rtl/led_pkg.sv
// Shared encodings for the LED scanner: display modes, scan direction and
// the pattern each mode starts from.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT    = 2'b00,
    MODE_PINGPONG = 2'b01,
    MODE_COUNT    = 2'b10,
    MODE_BLINK    = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [7:0] PAT_SHIFT    = 8'h01;
  localparam logic [7:0] PAT_PINGPONG = 8'h01;
  localparam logic [7:0] PAT_COUNT    = 8'h00;
  localparam logic [7:0] PAT_BLINK    = 8'h55;

  function automatic logic [7:0] init_pat(mode_e m);
    logic [7:0] p;
    case (m)
      MODE_SHIFT:    p = PAT_SHIFT;
      MODE_PINGPONG: p = PAT_PINGPONG;
      MODE_COUNT:    p = PAT_COUNT;
      default:       p = PAT_BLINK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_scanner_btn_edge.sv
// Push-button front end: 2-flop synchronizer plus registered rising-edge
// pulse, one cycle wide, three edges after the input rises.
module btn_edge (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic press_o
);

  logic       sync1_q, sync2_q, prev_q, armed_q, pulse_q;
  logic [1:0] prime_q;

  // A rise only counts once a genuine low level has made it through the
  // synchronizer, so a button held across reset release never fires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      prime_q <= 2'b00;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      prime_q <= {prime_q[0], 1'b1};
      armed_q <= armed_q | (prime_q[1] & ~sync2_q);
      pulse_q <= armed_q & sync2_q & ~prev_q;
    end
  end

  assign press_o = pulse_q;

endmodule

// File: rtl/led_scanner.sv
// Eight-LED pattern scanner: prescaled tick, four display modes cycled by
// SW1, pause toggled by SW2.
module led_scanner
  import led_pkg::*;
#(
  parameter int PRESC_BITS = 22
) (
  input  logic clk,
  input  logic rstn,
  input  logic SW1,
  input  logic SW2,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);

  localparam logic [PRESC_BITS-1:0] PRESC_ONE = 1;

  logic                  sw1_press, sw2_press, tick;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  mode_e                 mode_q, mode_d;
  dir_e                  dir_q, dir_d;
  logic [7:0]            pat_q, pat_d;
  logic                  paused_q, paused_d;

  btn_edge u_sw1 (.clk(clk), .rstn(rstn), .btn_i(SW1), .press_o(sw1_press));
  btn_edge u_sw2 (.clk(clk), .rstn(rstn), .btn_i(SW2), .press_o(sw2_press));

  assign tick = ~paused_q & (&presc_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q  <= '0;
      mode_q   <= MODE_SHIFT;
      dir_q    <= DIR_UP;
      pat_q    <= PAT_SHIFT;
      paused_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      pat_q    <= pat_d;
      paused_q <= paused_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    presc_d  = presc_q;
    paused_d = paused_q ^ sw2_press;
    if (sw1_press) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      presc_d = '0;
    end else if (!paused_q) begin
      presc_d = presc_q + PRESC_ONE;
    end
  end

  // A mode change takes priority over a tick landing in the same cycle.
  always_comb begin
    pat_d = pat_q;
    dir_d = dir_q;
    if (sw1_press) begin
      pat_d = init_pat(mode_d);
      dir_d = DIR_UP;
    end else if (tick) begin
      case (mode_q)
        MODE_SHIFT: pat_d = {pat_q[6:0], pat_q[7]};
        MODE_PINGPONG: begin
          if (dir_q == DIR_UP) begin
            if (pat_q[7]) begin
              dir_d = DIR_DOWN;
              pat_d = 8'h40;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = DIR_UP;
              pat_d = 8'h02;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        MODE_COUNT: pat_d = pat_q + 8'd1;
        default:    pat_d = ~pat_q;
      endcase
    end
  end

  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = pat_q;

endmodule

// File: tb/tb_led_scanner.sv
// Scoreboarded bench for led_scanner with a 4-cycle tick: a step-count model
// queues the expected LEDs each edge, a monitor compares on the falling edge.
module tb_led_scanner;

  localparam int PB     = 2;
  localparam int PERIOD = 1 << PB;

  logic clk = 1'b0, rstn = 1'b0, SW1 = 1'b0, SW2 = 1'b0;
  logic LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
  logic [7:0] leds;

  led_scanner #(.PRESC_BITS(PB)) dut (
    .clk(clk), .rstn(rstn), .SW1(SW1), .SW2(SW2),
    .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3),
    .LED4(LED4), .LED5(LED5), .LED6(LED6), .LED7(LED7)
  );

  always #5 clk = ~clk;
  assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  int checks = 0, failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern shown after `st` ticks since mode md was entered.
  function automatic int ref_pat(input int md, input int st);
    int p;
    case (md)
      0: return 1 << (st % 8);
      1: begin
        p = st % 14;
        return 1 << ((p < 8) ? p : 14 - p);
      end
      2: return st % 256;
      default: return (st % 2) ? 'hAA : 'h55;
    endcase
  endfunction

  int exp_q[$];
  int pend1[$], pend2[$];
  int m_mode = 0, m_step = 0, m_presc = 0, ecnt = 0;
  bit m_paused = 0, last1 = 0, last2 = 0;

  // Reference model: a press takes effect 3 edges after the first edge that
  // samples the button high following a sampled low since reset release.
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_mode = 0; m_step = 0; m_presc = 0; m_paused = 0; ecnt = 0;
      last1 = 0; last2 = 0;
      pend1.delete(); pend2.delete(); exp_q.delete();
      exp_q.push_back('h01);
    end else begin
      bit p1, p2, tk;
      ecnt++;
      p1 = 0; p2 = 0;
      if (pend1.size() > 0) if (pend1[0] == ecnt) begin p1 = 1; void'(pend1.pop_front()); end
      if (pend2.size() > 0) if (pend2[0] == ecnt) begin p2 = 1; void'(pend2.pop_front()); end
      tk = !m_paused && (m_presc == PERIOD - 1);
      if (p1) begin
        m_mode = (m_mode + 1) % 4; m_step = 0; m_presc = 0;
      end else begin
        if (tk) m_step++;
        if (!m_paused) m_presc = (m_presc + 1) % PERIOD;
      end
      if (p2) m_paused = !m_paused;
      if (ecnt >= 2 && SW1 && !last1) pend1.push_back(ecnt + 3);
      if (ecnt >= 2 && SW2 && !last2) pend2.push_back(ecnt + 3);
      last1 = SW1; last2 = SW2;
      exp_q.push_back(ref_pat(m_mode, m_step));
    end
  end

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) check("scoreboard", leds, exp_q.pop_front());
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_led(input string name, input int val, input int bound);
    for (int i = 0; i < bound && leds != val[7:0]; i++) @(negedge clk);
    check(name, leds, val);
  endtask

  task automatic press(input bit b1, input bit b2);
    SW1 = b1; SW2 = b2;
    cyc(2);
    SW1 = 0; SW2 = 0;
    cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    cyc(3);
    check("reset_led", leds, 'h01);
    rstn = 1;
    for (int i = 1; i <= 8; i++) wait_led("shift_seq", 1 << (i % 8), 2 * PERIOD);

    // SW1 pulse lands on the 0x04 -> 0x08 tick edge
    wait_led("shift_04", 'h04, 10 * PERIOD);
    SW1 = 1; cyc(2); SW1 = 0; cyc(2);
    check("coincide", leds, 'h01);

    for (int i = 1; i <= 15; i++) begin
      p = i % 14;
      wait_led("pingpong_seq", 1 << ((p < 8) ? p : 14 - p), 2 * PERIOD);
    end

    press(1, 0);
    wait_led("count_init", 'h00, 16);
    wait_led("count_ff", 'hFF, 260 * PERIOD);
    wait_led("count_wrap", 'h00, 2 * PERIOD);

    wait_led("count_37", 'h37, 60 * PERIOD);
    @(posedge clk); #2;
    rstn = 0;
    #1 check("async_rst", leds, 'h01);
    cyc(2);
    rstn = 1;
    wait_led("shift_after_rst", 'h02, 2 * PERIOD);

    // Pause request timed to take effect while 0x08 is showing
    wait_led("pause_04", 'h04, 10 * PERIOD);
    cyc(1);
    press(0, 1);
    cyc(100);
    check("pause_hold", leds, 'h08);
    press(0, 1);
    wait_led("unpause", 'h10, 10);

    press(0, 1);
    press(1, 0);
    cyc(20);
    check("paused_mode_chg", leds, 'h01);
    press(1, 1);
    wait_led("both_press", 'h01, 4 * PERIOD);

    // Button held through reset release must not register
    SW1 = 1; rstn = 0; cyc(2); rstn = 1; cyc(20); SW1 = 0; cyc(10);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: press(1, 0);
        1: press(0, 1);
        2: press(1, 1);
        default: ;
      endcase
      cyc($urandom_range(1, 25));
    end
    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
LED_SCANNER -- requirements
Module: led_scanner

Interface
REQ-001 The block SHALL have parameter PRESC_BITS, default 22, which sets the prescaler width; the step period is 2^PRESC_BITS clk cycles.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state is on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port SW1, input, 1 bit, an asynchronous push-button; its press selects the next mode.
REQ-005 The block SHALL have port SW2, input, 1 bit, an asynchronous push-button; its press toggles pause.
REQ-006 The block SHALL have ports LED0..LED7, output, 1 bit each, driven by pattern bits 0..7, active-high.

Function
REQ-007 The prescaler SHALL be a free-running PRESC_BITS-bit up-counter that asserts a one-cycle tick when it equals all-ones, then wraps to 0.
REQ-008 Each button SHALL pass through a 2-flop synchronizer and a rising-edge detector, producing a one-cycle press pulse 3 cycles after the input rises.
REQ-009 Mode SHALL be a 2-bit state: SHIFT=00, PINGPONG=01, COUNT=10, BLINK=11.
REQ-010 An SW1 press SHALL advance the mode by one, wrapping from BLINK to SHIFT.
REQ-011 An SW1 press SHALL load the new mode's initial pattern on the next edge, clear the prescaler, and set direction to up.
REQ-012 The initial patterns SHALL be: SHIFT=0x01, PINGPONG=0x01, COUNT=0x00, BLINK=0x55.
REQ-013 On a tick, SHIFT SHALL rotate the pattern left one position, with 0x80 going to 0x01.
REQ-014 On a tick, PINGPONG SHALL shift the single lit bit in the current direction.
REQ-015 In PINGPONG at 0x80 with direction up, direction SHALL flip to down and the next pattern SHALL be 0x40.
REQ-016 In PINGPONG at 0x01 with direction down, direction SHALL flip to up and the next pattern SHALL be 0x02.
REQ-017 On a tick, COUNT SHALL increment the pattern modulo 256, with 0xFF going to 0x00.
REQ-018 On a tick, BLINK SHALL invert the pattern, alternating 0x55 and 0xAA.
REQ-019 The pattern SHALL update on the clock edge after the tick cycle (latency 1), and LEDs SHALL be driven directly from the pattern register.
REQ-020 An SW2 press SHALL toggle the paused flag.
REQ-021 While paused, the prescaler SHALL hold its value, no tick SHALL occur, and the pattern SHALL be frozen.
REQ-022 SW1 presses SHALL still change mode while paused, and the paused flag SHALL stay set.
REQ-023 If an SW1 press and a tick occur in the same cycle, the mode change SHALL win and the tick SHALL be discarded.
REQ-024 If SW1 and SW2 presses occur in the same cycle, both SHALL take effect.
REQ-025 In SHIFT and PINGPONG the pattern SHALL never be 0x00 and SHALL always have exactly one bit set.

Reset
REQ-026 While rstn=0, the block SHALL force mode=SHIFT, pattern=0x01, direction=up, paused=0, prescaler=0, and all synchronizer and edge flops=0, immediately and independent of clk.
REQ-027 During reset, LED0 SHALL be 1 and LED1..LED7 SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL abort any mode and any in-flight button pulse, and no press SHALL be detected from a button already held at release.
REQ-029 After rstn is released, the first tick SHALL occur 2^PRESC_BITS cycles after the first active edge.

Structure
REQ-030 The mode encodings, initial-pattern constants and the direction encoding SHALL live in shared package led_pkg.
REQ-031 Sub-module btn_edge (synchronizer plus rising-edge pulse, with clk and rstn) SHALL be instantiated once for SW1 and once for SW2.
REQ-032 The prescaler, mode FSM and pattern register SHALL live in led_scanner.

Verification (PRESC_BITS=2, tick every 4 cycles)
REQ-033 The bench SHALL check reset: pulse rstn low, release -> LEDs 0x01, then on successive ticks 0x02, 0x04 ... 0x80, 0x01.
REQ-034 The bench SHALL check ping-pong: one SW1 press -> 0x01, then on ticks 0x02 ... 0x80, 0x40 ... 0x01, 0x02, with no blank pattern.
REQ-035 The bench SHALL check count wrap: two SW1 presses -> 0x00; after 255 ticks 0xFF, then the next tick gives 0x00.
REQ-036 The bench SHALL check pause: SW2 press at pattern 0x08 -> LEDs stay 0x08 for 100 cycles; a second SW2 press -> 0x10 after 4 cycles.
REQ-037 The bench SHALL check coincidence: an SW1 pulse aligned to the tick cycle in SHIFT at 0x04 -> next pattern 0x01 (PINGPONG initial), not 0x08.
REQ-038 The bench SHALL check async reset: rstn dropped mid-cycle in COUNT at 0x37 -> LEDs 0x01 before the next clk edge, and mode SHIFT after release.
